// File: rtl/inst_encoder_pkg.sv
// Shared constants and types for the RV32 instruction encoder.
// Holds the supported opcode set, the NOP filler word and the raw field bundle.
package inst_encoder_pkg;

    localparam int DATA_LEN = 32;
    localparam int IMM_SIZE = 32;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;

    localparam logic [DATA_LEN-1:0] NOP_WORD = 32'h0000_0013;

    typedef struct packed {
        logic [6:0]          opcode;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [IMM_SIZE-1:0] imm;
    } fields_t;

    // True when imm[31:msb] are all equal, i.e. imm fits a signed field of msb+1 bits.
    function automatic logic fits_signed(input logic [IMM_SIZE-1:0] imm, input int msb);
        logic [IMM_SIZE-1:0] s;
        s = $unsigned($signed(imm) >>> msb);
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/inst_encoder_pack.sv
// Combinational field scatter and legality check for one instruction.
// Illegal words come out as NOP with err_o set.
module inst_encoder_pack
    import inst_encoder_pkg::*;
(
    input  fields_t             f,
    output logic [DATA_LEN-1:0] inst_o,
    output logic                err_o
);

    logic [DATA_LEN-1:0] word;
    logic                legal;

    always_comb begin
        word  = NOP_WORD;
        legal = 1'b0;
        case (f.opcode)
            OP_R: begin
                word  = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
                legal = 1'b1;
            end
            OP_I, OP_LOAD: begin
                // Shift-immediates reuse funct7 and carry only a 5-bit unsigned shamt.
                if (f.opcode == OP_I && (f.funct3 == 3'b001 || f.funct3 == 3'b101)) begin
                    word  = {f.funct7, f.imm[4:0], f.rs1, f.funct3, f.rd, f.opcode};
                    legal = (f.imm[31:5] == 27'd0);
                end else begin
                    word  = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
                    legal = fits_signed(f.imm, 11);
                end
            end
            OP_S: begin
                word  = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
                legal = fits_signed(f.imm, 11);
            end
            OP_B: begin
                word  = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                         f.imm[4:1], f.imm[11], f.opcode};
                legal = fits_signed(f.imm, 12) && !f.imm[0];
            end
            default: begin
                word  = NOP_WORD;
                legal = 1'b0;
            end
        endcase
        inst_o = legal ? word : NOP_WORD;
        err_o  = !legal;
    end

endmodule

// File: rtl/inst_encoder.sv
// Two-stage valid/ready instruction assembler feeding instruction-memory preload.
// Stage 1 holds raw fields, stage 2 the encoded word; address and error counters track output transfers.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter logic [31:0] ADDR_STEP = 32'd4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] addr_o,
    output logic        err_o,
    output logic [7:0]  err_cnt_o
);

    logic        s1_valid_q, s1_valid_d;
    fields_t     s1_q, s1_d;
    logic        s2_valid_q, s2_valid_d;
    logic [31:0] inst_q, inst_d;
    logic        err_q, err_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic [31:0] pack_inst;
    logic        pack_err;
    logic        s1_adv, in_fire, out_fire;

    inst_encoder_pack u_pack (
        .f      (s1_q),
        .inst_o (pack_inst),
        .err_o  (pack_err)
    );

    assign s1_adv     = !s2_valid_q || out_ready_i;
    assign in_ready_o = !s1_valid_q || s1_adv;
    assign in_fire    = in_valid_i && in_ready_o;
    assign out_fire   = s2_valid_q && out_ready_i;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s2_valid_d = s2_valid_q;
        inst_d     = inst_q;
        err_d      = err_q;
        addr_d     = addr_q;
        err_cnt_d  = err_cnt_q;

        if (s1_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                inst_d = pack_inst;
                err_d  = pack_err;
            end
            s1_valid_d = 1'b0;
        end
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_d       = '{opcode: opcode_i, funct3: funct3_i, funct7: funct7_i,
                           rd: rd_i, rs1: rs1_i, rs2: rs2_i, imm: imm_i};
        end

        // clear_i outranks a same-cycle output transfer on both counters.
        if (clear_i) begin
            addr_d    = BASE_ADDR;
            err_cnt_d = 8'd0;
        end else if (out_fire) begin
            addr_d = addr_q + ADDR_STEP;
            if (err_q && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            inst_q     <= '0;
            err_q      <= 1'b0;
            addr_q     <= BASE_ADDR;
            err_cnt_q  <= 8'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            inst_q     <= inst_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign out_valid_o = s2_valid_q;
    assign inst_o      = inst_q;
    assign err_o       = err_q;
    assign addr_o      = addr_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: encoding table, backpressure, clear, saturation,
// decoder round-trip and asynchronous reset mid-stream.
module tb_inst_encoder;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [6:0]  opcode_i = '0;
    logic [2:0]  funct3_i = '0;
    logic [6:0]  funct7_i = '0;
    logic [4:0]  rd_i = '0, rs1_i = '0, rs2_i = '0;
    logic [31:0] imm_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [31:0] inst_o, addr_o;
    logic        err_o;
    logic [7:0]  err_cnt_o;

    inst_encoder dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .opcode_i(opcode_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
        .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .inst_o(inst_o), .addr_o(addr_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [31:0] exp_inst;
        logic        exp_err;
    } vec_t;

    vec_t        vecs[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_addr = 32'h0;
    logic [7:0]  exp_cnt = 8'd0;

    function automatic vec_t mk(string n, logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                                logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                logic [31:0] imm, logic [31:0] ei, logic ee);
        vec_t v;
        v.name = n; v.op = op; v.f3 = f3; v.f7 = f7; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.imm = imm; v.exp_inst = ei; v.exp_err = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timed out waiting for handshake", nm);
    endtask

    task automatic drive(input vec_t v);
        opcode_i = v.op; funct3_i = v.f3; funct7_i = v.f7;
        rd_i = v.rd; rs1_i = v.rs1; rs2_i = v.rs2; imm_i = v.imm;
    endtask

    // Push one word and sample it while out_valid_o is high; the following posedge consumes it.
    task automatic xfer(input vec_t v, output logic [31:0] inst, output logic err,
                        output logic [31:0] addr, output logic [7:0] cnt);
        int t;
        @(negedge clk_i);
        drive(v);
        in_valid_i = 1'b1;
        t = 0;
        while (!in_ready_o && t < 20) begin @(negedge clk_i); t++; end
        if (t == 20) timeout({v.name, "_in"});
        @(negedge clk_i);
        in_valid_i = 1'b0;
        t = 0;
        while (!out_valid_o && t < 20) begin @(negedge clk_i); t++; end
        if (t == 20) timeout({v.name, "_out"});
        inst = inst_o; err = err_o; addr = addr_o; cnt = err_cnt_o;
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] inst, addr;
        logic        err;
        logic [7:0]  cnt;
        xfer(v, inst, err, addr, cnt);
        chk({v.name, "_inst"}, inst, v.exp_inst);
        chk({v.name, "_err"}, {31'd0, err}, {31'd0, v.exp_err});
        chk({v.name, "_addr"}, addr, exp_addr);
        chk({v.name, "_cnt"}, {24'd0, cnt}, {24'd0, exp_cnt});
        exp_addr = exp_addr + 32'd4;
        if (v.exp_err && exp_cnt != 8'hFF) exp_cnt++;
    endtask

    function automatic logic [31:0] decode_imm(input logic [31:0] i);
        case (i[6:0])
            7'b0100011: return {{20{i[31]}}, i[31:25], i[11:7]};
            7'b1100011: return {{20{i[31]}}, i[31], i[7], i[30:25], i[11:8]};
            default:    return {{20{i[31]}}, i[31:20]};
        endcase
    endfunction

    initial begin
        vec_t        v, exp_q[$];
        logic [31:0] inst, addr;
        logic        err;
        logic [7:0]  cnt;
        int          k, n_out, n_busy;
        logic        pend;

        vecs.push_back(mk("addi_m1",    7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, -32'sd1,    32'hFFF00093, 1'b0));
        vecs.push_back(mk("sw_8",       7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,      32'h0020A423, 1'b0));
        vecs.push_back(mk("beq_m8",     7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, -32'sd8,    32'hFE208CE3, 1'b0));
        vecs.push_back(mk("srai_2",     7'h13, 3'd5, 7'h20, 5'd3, 5'd3, 5'd0, 32'd2,      32'h4021D193, 1'b0));
        vecs.push_back(mk("srai_32",    7'h13, 3'd5, 7'h20, 5'd3, 5'd3, 5'd0, 32'd32,     32'h00000013, 1'b1));
        vecs.push_back(mk("addi_2048",  7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048,   32'h00000013, 1'b1));
        vecs.push_back(mk("beq_7",      7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd7,      32'h00000013, 1'b1));
        vecs.push_back(mk("op_7f",      7'h7F, 3'd0, 7'h00, 5'd1, 5'd1, 5'd1, 32'd0,      32'h00000013, 1'b1));
        vecs.push_back(mk("beq_6",      7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd6,      32'h00208363, 1'b0));
        vecs.push_back(mk("lw_m4",      7'h03, 3'd2, 7'h00, 5'd5, 5'd2, 5'd0, -32'sd4,    32'hFFC12283, 1'b0));
        vecs.push_back(mk("add",        7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'd0,      32'h003100B3, 1'b0));
        vecs.push_back(mk("sub",        7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'd12345,  32'h403100B3, 1'b0));
        vecs.push_back(mk("slli_31",    7'h13, 3'd1, 7'h00, 5'd1, 5'd1, 5'd0, 32'd31,     32'h01F09093, 1'b0));
        vecs.push_back(mk("beq_4094",   7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd4094,   32'h7E000FE3, 1'b0));
        vecs.push_back(mk("beq_4096",   7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd4096,   32'h00000013, 1'b1));
        vecs.push_back(mk("sw_m2048",   7'h23, 3'd2, 7'h00, 5'd0, 5'd0, 5'd0, -32'sd2048, 32'h80002023, 1'b0));
        vecs.push_back(mk("addi_m2048", 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, -32'sd2048, 32'h80000093, 1'b0));
        vecs.push_back(mk("addi_m2049", 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, -32'sd2049, 32'h00000013, 1'b1));

        // Reset state
        #12;
        chk("rst_in_ready",  {31'd0, in_ready_o},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("rst_inst",      inst_o,               32'd0);
        chk("rst_err",       {31'd0, err_o},       32'd0);
        chk("rst_addr",      addr_o,               32'd0);
        chk("rst_cnt",       {24'd0, err_cnt_o},   32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure: two words fill the pipe, the third stalls, then all drain in order.
        @(negedge clk_i);
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            v = mk("bp", 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'(i + 1), 32'((i + 1) << 20) | 32'h93, 1'b0);
            exp_q.push_back(v);
        end
        for (int i = 0; i < 2; i++) begin
            drive(exp_q[i]);
            in_valid_i = 1'b1;
            chk("bp_ready_fill", {31'd0, in_ready_o}, 32'd1);
            @(negedge clk_i);
        end
        drive(exp_q[2]);
        for (int i = 0; i < 3; i++) begin
            chk("bp_ready_full", {31'd0, in_ready_o}, 32'd0);
            chk("bp_hold_inst", inst_o, exp_q[0].exp_inst);
            @(negedge clk_i);
        end
        out_ready_i = 1'b1;
        k = 0;
        pend = 1'b0;
        for (int c = 0; c < 20 && k < 3; c++) begin
            if (pend) begin in_valid_i = 1'b0; pend = 1'b0; end
            if (out_valid_o) begin
                chk("bp_order_inst", inst_o, exp_q[k].exp_inst);
                chk("bp_order_addr", addr_o, exp_addr);
                exp_addr = exp_addr + 32'd4;
                k++;
            end
            if (in_valid_i && in_ready_o) pend = 1'b1;
            @(negedge clk_i);
        end
        in_valid_i = 1'b0;
        chk("bp_drained", k, 3);

        // clear_i during an error-word transfer: clear wins on both counters.
        v = mk("clr_xfer", 7'h7F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0, 32'h13, 1'b1);
        xfer(v, inst, err, addr, cnt);
        chk("clr_xfer_err", {31'd0, err}, 32'd1);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        chk("clr_xfer_cnt", {24'd0, err_cnt_o}, 32'd0);
        exp_addr = 32'h0;
        exp_cnt = 8'd0;
        run_vec(vecs[0]);

        // Streaming illegal words at full rate: no stall, no loss, counter saturates.
        @(negedge clk_i);
        opcode_i = 7'h7F;
        n_out = 0;
        n_busy = 0;
        for (int c = 0; c < 306; c++) begin
            if (out_valid_o) begin n_out++; exp_addr = exp_addr + 32'd4; end
            if (c < 300 && !in_ready_o) n_busy++;
            in_valid_i = (c < 300);
            @(negedge clk_i);
        end
        in_valid_i = 1'b0;
        chk("stream_count", n_out, 300);
        chk("stream_no_stall", n_busy, 0);
        chk("stream_sat", {24'd0, err_cnt_o}, 32'hFF);
        exp_cnt = 8'hFF;
        run_vec(vecs[4]);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        chk("clear_idle_cnt",  {24'd0, err_cnt_o}, 32'd0);
        chk("clear_idle_addr", addr_o, 32'd0);
        exp_addr = 32'h0;
        exp_cnt = 8'd0;

        // Round-trip through a sign-extend decoder on random legal immediates.
        for (int i = 0; i < 16; i++) begin
            int r;
            logic [31:0] want;
            r = int'($urandom_range(4095, 0)) - 2048;
            case (i % 4)
                0: v = mk("rt_i", 7'h13, 3'd0, 7'h00, 5'd7, 5'd9, 5'd0, 32'(r), 32'h0, 1'b0);
                1: v = mk("rt_ld", 7'h03, 3'd2, 7'h00, 5'd7, 5'd9, 5'd0, 32'(r), 32'h0, 1'b0);
                2: v = mk("rt_s", 7'h23, 3'd2, 7'h00, 5'd0, 5'd9, 5'd4, 32'(r), 32'h0, 1'b0);
                default: v = mk("rt_b", 7'h63, 3'd1, 7'h00, 5'd0, 5'd9, 5'd4, 32'(r * 2), 32'h0, 1'b0);
            endcase
            want = (v.op == 7'h63) ? $unsigned($signed(v.imm) >>> 1) : v.imm;
            xfer(v, inst, err, addr, cnt);
            chk({v.name, "_imm"}, decode_imm(inst), want);
            chk({v.name, "_err"}, {31'd0, err}, 32'd0);
            exp_addr = exp_addr + 32'd4;
        end

        // Asynchronous reset with a word held at the output.
        @(negedge clk_i);
        out_ready_i = 1'b0;
        drive(vecs[1]);
        in_valid_i = 1'b1;
        @(negedge clk_i);
        in_valid_i = 1'b0;
        k = 0;
        while (!out_valid_o && k < 20) begin @(negedge clk_i); k++; end
        if (k == 20) timeout("mid_rst_fill");
        #2 rst_i = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("mid_rst_in_ready",  {31'd0, in_ready_o},  32'd1);
        chk("mid_rst_inst",      inst_o,               32'd0);
        chk("mid_rst_addr",      addr_o,               32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        out_ready_i = 1'b1;
        exp_addr = 32'h0;
        exp_cnt = 8'd0;
        run_vec(vecs[2]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
